// File: rtl/count_sequencer.sv
// Prescaled up/down counter sequencer with one-shot or auto-reload,
// pause/stop control, terminal-count pulse and a saturating reload count.
module count_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             re,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [WIDTH-1:0] limit,
    input  logic             dir,
    input  logic             auto,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] wraps
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_wraps;
    logic             r_done;
    logic             r_busy;
    logic [PW-1:0]    r_psc;
    logic [WIDTH-1:0] r_lim;
    logic             r_dir;
    logic             r_auto;

    logic [WIDTH-1:0] w_s_new;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_q_next;
    logic             w_lim_zero;
    logic             w_wr_sat;

    assign w_s_new    = dir ? limit : '0;
    assign w_s        = r_dir ? r_lim : '0;
    assign w_t        = r_dir ? '0 : r_lim;
    assign w_q_next   = r_dir ? (r_q - WIDTH'(1)) : (r_q + WIDTH'(1));
    assign w_lim_zero = (limit == '0);
    assign w_wr_sat   = &r_wraps;

    always_ff @(posedge clk) begin
        if (re) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_wraps <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_psc   <= '0;
            r_lim   <= '0;
            r_dir   <= 1'b0;
            r_auto  <= 1'b0;
        end else if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_psc   <= '0;
            r_done  <= 1'b0;
        end else if (start) begin
            r_lim   <= limit;
            r_dir   <= dir;
            r_auto  <= auto;
            r_q     <= w_s_new;
            r_psc   <= '0;
            r_wraps <= '0;
            r_done  <= w_lim_zero;
            // A zero limit means start already equals terminal.
            if (w_lim_zero && !auto) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
            end else begin
                r_state <= RUN;
                r_busy  <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                RUN: begin
                    if (pause) begin
                        r_state <= HOLD;
                    end else if (r_psc == PS_LAST) begin
                        r_psc <= '0;
                        if (r_q != w_t) begin
                            r_q <= w_q_next;
                            if (w_q_next == w_t) begin
                                r_done <= 1'b1;
                                if (!r_auto) begin
                                    r_state <= DONE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end else begin
                            r_q    <= w_s;
                            r_done <= (w_s == w_t);
                            if (!w_wr_sat)
                                r_wraps <= r_wraps + WIDTH'(1);
                        end
                    end else begin
                        r_psc <= r_psc + PW'(1);
                    end
                end
                HOLD: begin
                    if (!pause)
                        r_state <= RUN;
                end
                default: begin
                end
            endcase
        end
    end

    assign q     = r_q;
    assign busy  = r_busy;
    assign done  = r_done;
    assign state = r_state;
    assign wraps = r_wraps;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: two instances (prescale 1 and 3) run
// against a countdown-based reference model under directed and random stimulus.
module tb_count_sequencer;

    logic       clk = 1'b0;
    logic       re = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] limit = 8'd0;
    logic       dir = 1'b0;
    logic       auto = 1'b0;

    logic [7:0] q0, q1, wr0, wr1;
    logic [1:0] st0, st1;
    logic       busy0, busy1, done0, done1;
    logic [19:0] obs [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    count_sequencer #(.WIDTH(8), .PRESCALE(1)) u0 (
        .clk(clk), .re(re), .start(start), .stop(stop), .pause(pause),
        .limit(limit), .dir(dir), .auto(auto),
        .q(q0), .busy(busy0), .done(done0), .state(st0), .wraps(wr0)
    );

    count_sequencer #(.WIDTH(8), .PRESCALE(3)) u1 (
        .clk(clk), .re(re), .start(start), .stop(stop), .pause(pause),
        .limit(limit), .dir(dir), .auto(auto),
        .q(q1), .busy(busy1), .done(done1), .state(st1), .wraps(wr1)
    );

    assign obs[0] = {q0, st0, busy0, done0, wr0};
    assign obs[1] = {q1, st1, busy1, done1, wr1};

    // Reference model: m_cd counts edges remaining until the next step.
    int m_q[2], m_st[2], m_wr[2], m_dn[2], m_cd[2];
    int m_lim[2], m_dr[2], m_au[2];

    function automatic int ps(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_edge(int i);
        int s, t;
        if (re) begin
            m_q[i] = 0; m_st[i] = 0; m_wr[i] = 0; m_dn[i] = 0;
            m_cd[i] = ps(i);
        end else if (stop) begin
            m_st[i] = 0; m_dn[i] = 0; m_cd[i] = ps(i);
        end else if (start) begin
            m_lim[i] = int'(limit); m_dr[i] = int'(dir); m_au[i] = int'(auto);
            m_q[i] = dir ? int'(limit) : 0;
            m_wr[i] = 0; m_cd[i] = ps(i);
            m_dn[i] = (limit == 0) ? 1 : 0;
            m_st[i] = (limit == 0 && !auto) ? 3 : 1;
        end else begin
            m_dn[i] = 0;
            if (m_st[i] == 1) begin
                if (pause) begin
                    m_st[i] = 2;
                end else begin
                    m_cd[i] = m_cd[i] - 1;
                    if (m_cd[i] == 0) begin
                        m_cd[i] = ps(i);
                        s = m_dr[i] ? m_lim[i] : 0;
                        t = m_dr[i] ? 0 : m_lim[i];
                        if (m_q[i] != t) begin
                            m_q[i] = m_q[i] + (m_dr[i] ? -1 : 1);
                            if (m_q[i] == t) begin
                                m_dn[i] = 1;
                                if (!m_au[i]) m_st[i] = 3;
                            end
                        end else begin
                            m_q[i] = s;
                            if (m_wr[i] < 255) m_wr[i] = m_wr[i] + 1;
                            m_dn[i] = (s == t) ? 1 : 0;
                        end
                    end
                end
            end else if (m_st[i] == 2) begin
                if (!pause) m_st[i] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_edge(i);
    end

    function automatic logic [19:0] mexp(int i);
        logic b;
        b = (m_st[i] == 1 || m_st[i] == 2);
        return {8'(m_q[i]), 2'(m_st[i]), b, 1'(m_dn[i]), 8'(m_wr[i])};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        re = 1'b1;
        cyc();
        cyc();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 20'h0) begin
                failures++;
                $display("FAIL reset_init inst%0d got=%h exp=%h", i, obs[i], 20'h0);
            end
        end
        re = 1'b0; limit = 8'd10; dir = 1'b0; auto = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        checks++;
        if (q0 !== 8'd5 || st0 !== 2'd1) begin
            failures++;
            $display("FAIL reset_pre q=%0d st=%0d exp q=5 st=1", q0, st0);
        end
        re = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== 20'h0) begin
                failures++;
                $display("FAIL reset_mid inst%0d got=%h exp=%h", i, obs[i], 20'h0);
            end
        end
        cyc();
        re = 1'b0;
    endtask

    task automatic test_oneshot_up();
        limit = 8'd4; dir = 1'b0; auto = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            logic [7:0] eq;
            logic       ed;
            eq = (k < 4) ? 8'(k) : 8'd4;
            ed = (k == 4);
            checks++;
            if (q0 !== eq || done0 !== ed || st0 !== ((k < 4) ? 2'd1 : 2'd3)) begin
                failures++;
                $display("FAIL oneshot_up k=%0d q=%0d done=%b st=%0d exp q=%0d done=%b",
                         k, q0, done0, st0, eq, ed);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== mexp(i)) begin
                    failures++;
                    $display("FAIL oneshot_up_model inst%0d got=%h exp=%h", i, obs[i], mexp(i));
                end
            end
            cyc();
        end
    endtask

    task automatic test_auto_down();
        limit = 8'd3; dir = 1'b1; auto = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            logic [7:0] eq, ew;
            eq = 8'(3 - (k % 4));
            ew = 8'(k / 4);
            checks++;
            if (q0 !== eq || wr0 !== ew || done0 !== (k % 4 == 3) || busy0 !== 1'b1) begin
                failures++;
                $display("FAIL auto_down k=%0d q=%0d wr=%0d done=%b busy=%b exp q=%0d wr=%0d",
                         k, q0, wr0, done0, busy0, eq, ew);
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== mexp(i)) begin
                    failures++;
                    $display("FAIL auto_down_model inst%0d got=%h exp=%h", i, obs[i], mexp(i));
                end
            end
            cyc();
        end
    endtask

    task automatic test_prescale();
        limit = 8'd2; dir = 1'b0; auto = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            logic [7:0] eq;
            eq = (k < 6) ? 8'(k / 3) : 8'd2;
            checks++;
            if (q1 !== eq || done1 !== (k == 6)) begin
                failures++;
                $display("FAIL prescale k=%0d q=%0d done=%b exp q=%0d done=%b",
                         k, q1, done1, eq, (k == 6));
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== mexp(i)) begin
                    failures++;
                    $display("FAIL prescale_model inst%0d got=%h exp=%h", i, obs[i], mexp(i));
                end
            end
            cyc();
        end
    endtask

    task automatic test_pause_stop();
        limit = 8'd6; dir = 1'b0; auto = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            checks++;
            if (q0 !== 8'd2 || st0 !== 2'd2 || done0 !== 1'b0 || busy0 !== 1'b1) begin
                failures++;
                $display("FAIL pause_hold k=%0d q=%0d st=%0d exp q=2 st=2", k, q0, st0);
            end
        end
        pause = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== mexp(i)) begin
                    failures++;
                    $display("FAIL pause_resume inst%0d got=%h exp=%h", i, obs[i], mexp(i));
                end
            end
        end
        checks++;
        if (q0 !== 8'd6 || st0 !== 2'd3) begin
            failures++;
            $display("FAIL pause_end q=%0d st=%0d exp q=6 st=3", q0, st0);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        checks++;
        if (q0 !== 8'd3 || st0 !== 2'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL stop q=%0d st=%0d busy=%b done=%b exp q=3 st=0", q0, st0, busy0, done0);
        end
        cyc();
    endtask

    task automatic test_edges();
        limit = 8'd0; dir = 1'b0; auto = 1'b0; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs[i] !== {8'd0, 2'd3, 1'b0, 1'b1, 8'd0}) begin
                failures++;
                $display("FAIL limit0 inst%0d got=%h exp=%h", i, obs[i],
                         {8'd0, 2'd3, 1'b0, 1'b1, 8'd0});
            end
        end
        cyc();
        checks++;
        if (done0 !== 1'b0 || st0 !== 2'd3) begin
            failures++;
            $display("FAIL limit0_after done=%b st=%0d exp done=0 st=3", done0, st0);
        end
        auto = 1'b1; start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 300; k++) cyc();
        checks++;
        if (wr0 !== 8'd255 || done0 !== 1'b1 || wr1 !== 8'd100) begin
            failures++;
            $display("FAIL wraps_sat wr0=%0d done0=%b wr1=%0d exp 255 1 100", wr0, done0, wr1);
        end
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        checks++;
        if (st0 !== 2'd0 || st1 !== 2'd0 || done0 !== 1'b0) begin
            failures++;
            $display("FAIL start_stop st0=%0d st1=%0d done0=%b exp 0 0 0", st0, st1, done0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            re    = ($urandom_range(0, 299) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            start = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            limit = 8'($urandom_range(0, 7));
            dir   = 1'($urandom);
            auto  = 1'($urandom);
            cyc();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs[i] !== mexp(i)) begin
                    failures++;
                    $display("FAIL random k=%0d inst%0d got=%h exp=%h", k, i, obs[i], mexp(i));
                end
            end
        end
        re = 1'b0; stop = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot_up();
        test_auto_down();
        test_prescale();
        test_pause_stop();
        test_edges();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Controller that sequences a WIDTH-bit counter for the counter datapath blocks in this design. It loads a start value, runs the count up or down at a prescaled rate, and detects the terminal value. Modes are one-shot or auto-reload, with pause and stop control. It exposes the count, busy/done status and a reload counter to the surrounding logic. The usual consumer is a timer/event-count front end that drives it with start/stop pulses.

Parameters:
WIDTH, 8, counter and limit width in bits
PRESCALE, 1, clock cycles per count step (>=1); 1 = step every cycle in RUN

Ports:
clk  input  1  system clock, all logic on rising edge
re  input  1  synchronous active-high reset
start  input  1  load and begin counting; samples limit/dir/auto
stop  input  1  abort to IDLE, q holds
pause  input  1  level; while high in RUN/HOLD, counting frozen
limit  input  WIDTH  terminal (up) or start (down) value
dir  input  1  0 = up (0 -> limit), 1 = down (limit -> 0)
auto  input  1  0 = one-shot, 1 = auto-reload
q  output  WIDTH  current count (registered)
busy  output  1  high in RUN or HOLD
done  output  1  one-cycle pulse when q reaches terminal value
state  output  2  IDLE=0, RUN=1, HOLD=2, DONE=3
wraps  output  WIDTH  number of auto-reloads since start, saturating at all-ones

Behaviour:
- Interface: one clock (clk); reset re is synchronous and active-high.
- Reset (re=1 at an edge): q=0, state=IDLE, busy=0, done=0, wraps=0, prescaler=0. This applies mid-operation and overrides all other inputs.
- Priority at each edge: re > stop > start > pause.
- Config registers: limit, dir and auto are captured only on an accepted start. Changes on these inputs at any other time are ignored.
- Start value S = 0 if up, limit if down. Terminal T = limit if up, 0 if down.
- start (any state, including RUN/HOLD = restart):
  - q<=S, prescaler<=0, wraps<=0, state<=RUN.
  - If S==T (limit==0): done=1 on that same edge. One-shot then goes to DONE instead of RUN.
- Step: in RUN, a step occurs on the edge where the prescaler equals PRESCALE-1 (the prescaler then returns to 0). Otherwise the prescaler increments. The first step happens PRESCALE edges after the start edge.
- On a step:
  - If q!=T: q moves one toward T (+1 up, -1 down). If the new q==T, done=1 on that edge. One-shot then goes to DONE; auto stays in RUN.
  - If q==T (auto only): q<=S and wraps<=wraps+1, saturating. done=0 unless S==T, in which case done=1 on every step.
- No arithmetic wrap past T or past 0/all-ones ever occurs.
- pause=1 in RUN: state<=HOLD; q and prescaler frozen.
  - pause=0 in HOLD: state<=RUN; the prescaler resumes from its frozen value.
  - pause is ignored in IDLE/DONE.
- stop: state<=IDLE from any state; q and wraps hold; prescaler<=0; done=0.
- DONE: q holds T, busy=0. Leaves only on start, stop or re.
- done is registered and high for exactly one cycle per terminal arrival. It is never asserted in IDLE or HOLD.
- busy = (state==RUN or state==HOLD), registered consistently with state.
- start and stop together: stop wins (IDLE).
- start and pause together in RUN: the restart happens and state=RUN; pause is evaluated on the following edges.

Test Plan:
- Reset: drive re=1 for 2 cycles mid-RUN with q=5 -> q=0, state=0, busy=0, done=0, wraps=0 after the first re edge.
- One-shot up, PRESCALE=1, limit=4, dir=0, auto=0, start pulse:
  - q=0,1,2,3,4 on consecutive edges.
  - done high only on the edge q becomes 4; state=DONE; q stays 4 for 10 further cycles.
- Auto-reload down, limit=3, dir=1, auto=1, run 12 cycles:
  - q=3,2,1,0,3,2,1,0,...; done pulses each time q reaches 0.
  - wraps increments 1,2 at each reload; busy stays high.
- PRESCALE=3, limit=2, up one-shot: q changes only every 3rd edge after start (edges 3 and 6); done on edge 6.
- Pause/stop:
  - In RUN at q=2, hold pause for 5 cycles -> state=HOLD, q=2 frozen; release -> counting resumes to limit.
  - stop at q=3 -> state=IDLE, q=3, busy=0, no done.
- Edge cases:
  - limit=0 one-shot start -> done on the start edge, state=DONE.
  - Auto-reload wraps saturates at 255 after more than 255 reloads (limit=0, auto=1).
  - start+stop in the same cycle -> IDLE.
